// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the 8N1 UART receiver.
//   rx_state_e      : receive FSM state encoding (3 bits)
//   DATA_BITS       : data bits per frame
//   STOP_BITS       : stop bits per frame
//   mid_start_count : divider count at which the start bit is re-sampled
//   frame_clks      : clock cycles spanned by one complete frame
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } rx_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  // Half a bit period minus one, so the start bit is checked at its centre.
  function automatic int unsigned mid_start_count(input int unsigned clks_per_bit);
    return clks_per_bit / 2 - 1;
  endfunction

  function automatic int unsigned frame_clks(input int unsigned clks_per_bit);
    return clks_per_bit * (1 + DATA_BITS + STOP_BITS);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
//   clk, resetb : clock and asynchronous active-low reset
//   push        : write push_data (accepted when not full, or when full with a same-cycle pop)
//   pop         : remove the head entry (ignored when empty)
//   head        : current head entry, forced to 0 while empty
//   empty, full : occupancy flags
//   count       : occupancy, 0..DEPTH
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_en, pop_en;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CntW'(DEPTH));
  assign pop_en = pop && !empty;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign push_en = push && (!full || pop);

  always_comb begin
    count_d = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through receive FIFO.
//   clk, resetb  : clock and asynchronous active-low reset
//   rxd          : asynchronous serial input, idle high
//   rx_data      : FIFO head byte, valid while rx_valid
//   rx_valid     : FIFO not empty
//   rx_ready     : consumer pops the head when rx_valid && rx_ready
//   frame_err    : one-cycle pulse when a stop bit samples low
//   overflow     : sticky, set when a byte is dropped on a full FIFO
//   clr_overflow : synchronous clear of overflow (a same-cycle drop wins)
//   fifo_count   : FIFO occupancy
//   busy         : receive FSM is not idle
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                        clk,
  input  logic                        resetb,
  input  logic                        rxd,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        frame_err,
  output logic                        overflow,
  input  logic                        clr_overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy
);

  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CntMid  = CNT_W'(mid_start_count(CLKS_PER_BIT));
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0]  IdxLast = IdxW'(DATA_BITS - 1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0]  bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             rxd_meta_q, rxd_s_q;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q, overflow_d;
  logic             line, push, pop, fifo_empty, fifo_full, drop;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  assign line = rxd_s_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (!line) state_d = StStart;
      StStart:    if (cnt_q == CntMid) state_d = line ? StIdle : StData;
      StData:     if (cnt_q == CntLast && bit_idx_q == IdxLast) state_d = StStop;
      StStop:     if (cnt_q == CntLast) state_d = line ? StIdle : StWaitHigh;
      StWaitHigh: if (line) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Bit-period divider, bit index and shift register.
  always_comb begin
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    case (state_q)
      StStart: begin
        if (cnt_q == CntMid) begin
          cnt_d     = '0;
          bit_idx_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          shreg_d   = {line, shreg_q[7:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + IdxW'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StStop: cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CNT_W'(1);
      default: cnt_d = '0;
    endcase
  end

  always_comb begin
    push        = 1'b0;
    frame_err_d = 1'b0;
    busy        = (state_q != StIdle);
    if (state_q == StStop && cnt_q == CntLast) begin
      push        = line;
      frame_err_d = !line;
    end
  end

  assign pop  = rx_valid && rx_ready;
  assign drop = push && fifo_full && !pop;

  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  sync_fifo_fwft #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetb   (resetb),
    .push     (push),
    .push_data(shreg_q),
    .pop      (pop),
    .head     (rx_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  assign rx_valid  = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed, table-driven bench for uart_rx_fifo at 16 clocks per bit.
module tb_uart_rx_fifo;
  import uart_rx_pkg::*;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic       clr_overflow = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overflow, busy;
  logic [4:0] fifo_count;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] got_q[$];
  int         fe_count = 0;
  int         valid_cycles = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_push;
    logic [7:0] exp_data;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .resetb      (resetb),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .clr_overflow(clr_overflow),
    .fifo_count  (fifo_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; this observes the settled values
  // that the next rising edge will act on.
  always begin
    @(negedge clk);
    #1;
    if (rx_valid) valid_cycles++;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) fe_count++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    fe_count     = 0;
    valid_cycles = 0;
  endtask

  // Drives the first nbits bits of {stop, data, start}, LSB first.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int nbits);
    logic [9:0] frame;
    frame = {stop, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rxd = frame[i];
      repeat (CPB) @(negedge clk);
    end
    if (nbits == 10) rxd = 1'b1;
  endtask

  initial begin
    vecs[0] = '{data: 8'h55, stop: 1'b1, exp_push: 1, exp_data: 8'h55, exp_fe: 0};
    vecs[1] = '{data: 8'hA3, stop: 1'b1, exp_push: 1, exp_data: 8'hA3, exp_fe: 0};
    vecs[2] = '{data: 8'h00, stop: 1'b1, exp_push: 1, exp_data: 8'h00, exp_fe: 0};
    vecs[3] = '{data: 8'hFF, stop: 1'b1, exp_push: 1, exp_data: 8'hFF, exp_fe: 0};
    vecs[4] = '{data: 8'h3C, stop: 1'b0, exp_push: 0, exp_data: 8'h00, exp_fe: 1};
    vecs[5] = '{data: 8'h81, stop: 1'b1, exp_push: 1, exp_data: 8'h81, exp_fe: 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_data", rx_data, 0);
    check("reset fifo_count", fifo_count, 0);
    check("reset overflow", overflow, 0);
    check("reset frame_err", frame_err, 0);
    check("reset busy", busy, 0);
    resetb = 1'b1;
    repeat (4) @(negedge clk);

    // Single frames, consumer always ready
    rx_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      clear_mon();
      send_frame(vecs[v].data, vecs[v].stop, 10);
      repeat (8) @(negedge clk);
      check($sformatf("vec%0d bytes", v), got_q.size(), vecs[v].exp_push);
      if (vecs[v].exp_push == 1 && got_q.size() > 0)
        check($sformatf("vec%0d rx_data", v), got_q[0], vecs[v].exp_data);
      check($sformatf("vec%0d valid cycles", v), valid_cycles, vecs[v].exp_push);
      check($sformatf("vec%0d frame_err", v), fe_count, vecs[v].exp_fe);
      check($sformatf("vec%0d busy", v), busy, 0);
    end

    // Fill to full, then one more byte is dropped
    clear_mon();
    rx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send_frame(8'(i), 1'b1, 10);
      check($sformatf("fill count %0d", i), fifo_count, i + 1);
    end
    check("pre-drop overflow", overflow, 0);
    send_frame(8'hEE, 1'b1, 10);
    repeat (4) @(negedge clk);
    check("full count", fifo_count, 16);
    check("overflow set", overflow, 1);
    rx_ready = 1'b1;
    repeat (24) @(negedge clk);
    check("drain bytes", got_q.size(), 16);
    if (got_q.size() == 16)
      for (int i = 0; i < 16; i++) check($sformatf("drain %0d", i), got_q[i], i);
    check("drained count", fifo_count, 0);
    check("overflow sticky", overflow, 1);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check("overflow cleared", overflow, 0);

    // Start-bit glitch shorter than half a bit
    clear_mon();
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch busy", busy, 1);
    @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch idle", busy, 0);
    check("glitch count", fifo_count, 0);
    check("glitch frame_err", fe_count, 0);
    check("glitch bytes", got_q.size(), 0);

    // Bad stop bit followed by a held-low break, then a clean frame
    clear_mon();
    send_frame(8'h3C, 1'b0, 9);
    rxd = 1'b0;
    repeat (CPB + 40) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h81, 1'b1, 10);
    repeat (8) @(negedge clk);
    check("break frame_err pulses", fe_count, 1);
    check("break bytes", got_q.size(), 1);
    if (got_q.size() > 0) check("break rx_data", got_q[0], 8'h81);

    // Full FIFO with a pop exactly on the stop-sample edge of a new byte
    clear_mon();
    rx_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1, 10);
    check("full2 count", fifo_count, 16);
    fork
      send_frame(8'h7E, 1'b1, 10);
      begin
        // Stop sample lands on the 155th rising edge after the start bit.
        repeat (154) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("push+pop count", fifo_count, 16);
    check("push+pop overflow", overflow, 0);
    check("push+pop popped", got_q.size(), 1);
    if (got_q.size() > 0) check("push+pop head", got_q[0], 8'h20);
    clear_mon();
    rx_ready = 1'b1;
    repeat (frame_clks(CPB) / 4) @(negedge clk);
    check("push+pop drain bytes", got_q.size(), 16);
    if (got_q.size() == 16) begin
      for (int i = 0; i < 15; i++) check($sformatf("p+p drain %0d", i), got_q[i], 8'h21 + i);
      check("p+p drain last", got_q[15], 8'h7E);
    end

    // Reset in the middle of a frame with bytes queued
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 10);
    send_frame(8'h22, 1'b1, 10);
    check("queued count", fifo_count, 2);
    send_frame(8'h5A, 1'b1, 4);
    check("mid-frame busy", busy, 1);
    resetb = 1'b0;
    #1;
    check("async reset rx_valid", rx_valid, 0);
    check("async reset count", fifo_count, 0);
    check("async reset busy", busy, 0);
    check("async reset rx_data", rx_data, 0);
    check("async reset overflow", overflow, 0);
    rxd = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    repeat (5) @(negedge clk);
    clear_mon();
    rx_ready = 1'b1;
    send_frame(8'h12, 1'b1, 10);
    repeat (8) @(negedge clk);
    check("post-reset bytes", got_q.size(), 1);
    if (got_q.size() > 0) check("post-reset rx_data", got_q[0], 8'h12);
    check("post-reset frame_err", fe_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Synthesizable 8N1 UART receiver with a receive FIFO. It sits directly downstream of a Marmot UART TX pin on mprj_io (uart0_tx) and feeds the bench console/checker through a valid/ready byte stream. It samples the line at mid-bit using a fixed clocks-per-bit divider and buffers received bytes. Framing errors and overflow are reported as status flags.

Parameters:
CLKS_PER_BIT, 217, clk cycles per UART bit (25 MHz / 115200); legal range 4..65535
FIFO_DEPTH, 16, receive FIFO entries; power of two, 2..256
CNT_W, 16, bit-period counter width; must satisfy 2^CNT_W > CLKS_PER_BIT

Ports:
clk  input  1  single clock; all logic on its rising edge
resetb  input  1  asynchronous active-low reset
rxd  input  1  serial line from the DUT TX pin; idle high; asynchronous to clk
rx_data  output  8  FIFO head byte; valid only while rx_valid=1
rx_valid  output  1  FIFO not empty
rx_ready  input  1  consumer accepts the head byte when rx_valid&&rx_ready
frame_err  output  1  one-cycle pulse when the stop bit samples 0
overflow  output  1  sticky flag; set when a byte is dropped because the FIFO is full
clr_overflow  input  1  synchronous clear of overflow
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
busy  output  1  receive FSM is not IDLE

Behaviour:
- Reset (resetb=0, asynchronous): FSM=IDLE, counters=0, FIFO empty. Synchroniser flops reset to 1. Outputs: rx_data=0, rx_valid=0, frame_err=0, overflow=0, fifo_count=0, busy=0.
- rxd passes through a 2-flop synchroniser (rxd_s). Every reference to "line" below means rxd_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when the line is 0, go to START and set cnt=0.
- START: when cnt==CLKS_PER_BIT/2-1 (integer division), sample the line.
  - 1 = glitch: go to IDLE; nothing is pushed and no error is flagged.
  - 0: go to DATA with cnt=0 and bit_idx=0.
  - Otherwise cnt++.
- DATA: when cnt==CLKS_PER_BIT-1, shift the line sample into shreg. Bits are LSB first: shreg <= {line, shreg[7:1]}. Set cnt=0 and bit_idx++. After bit 7, go to STOP.
- STOP: when cnt==CLKS_PER_BIT-1, sample the line.
  - 1: push shreg, go to IDLE.
  - 0: pulse frame_err for 1 cycle, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until the line is 1, then go to IDLE. A held-low break produces exactly one frame_err.
- Push latency: the byte is written on the stop-sample edge; rx_valid rises on the next cycle.
- Back-to-back frames: a start edge seen in IDLE on the cycle after STOP is accepted, so there is no dead bit.
- FIFO: first-word-fall-through. rx_data is the head, registered storage.
  - Pop occurs when rx_valid&&rx_ready.
  - Pop when empty is ignored.
- Push when full without a same-cycle pop: the byte is dropped and overflow is set. FIFO contents are unchanged.
- Push when full with a same-cycle pop: both take effect; the count stays FIFO_DEPTH and overflow is unchanged.
- Push and pop in the same cycle when not empty: the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- Overflow flag: clr_overflow=1 clears it. If a drop and clr_overflow occur in the same cycle, set wins.
- busy=1 in every state except IDLE.
- Reset mid-frame: a partial byte is discarded, the FIFO is emptied, and receive restarts from IDLE once resetb=1.

Decomposition:
- Package uart_rx_pkg holds:
  - the FSM state enum (5 states, 3-bit encoding);
  - the constants DATA_BITS=8 and STOP_BITS=1;
  - a function computing the mid-start count from CLKS_PER_BIT.
- One sub-module, sync_fifo_fwft:
  - parameters WIDTH=8, DEPTH=FIFO_DEPTH;
  - ports push, push_data, pop, head, empty, full, count.
- The top module contains the synchroniser, the FSM/divider and the overflow logic.

Test Plan:
- CLKS_PER_BIT=16; send 0x55 then 0xA3 with rx_ready=1 -> rx_data 0x55 then 0xA3, each for one cycle of rx_valid; frame_err never asserts.
- rx_ready=0; send 16 bytes 0x00..0x0F, then 0xEE -> fifo_count=16 and overflow=1. Drain order is 0x00..0x0F; 0xEE is absent.
- Glitch: rxd low for 5 cycles (< 8) -> FSM returns to IDLE, no push, fifo_count=0, frame_err=0.
- Frame 0x3C with stop bit 0, then line low for 40 cycles, then valid frame 0x81 -> exactly one frame_err pulse; only 0x81 is received.
- FIFO full with rx_ready=1 during the stop sample of a new byte 0x7E -> head pops, 0x7E is stored, count stays 16, overflow=0.
- Assert resetb=0 during DATA of frame 0x5A with 2 bytes queued -> all outputs go to their reset values immediately. The next clean frame 0x12 is received correctly.
